// File: rtl/alarm_pkg.sv
// Shared state encoding and time-field widths for the alarm clock control path.
package alarm_pkg;
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } alarm_state_t;

    localparam int TIME_W = 17;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
endpackage

// File: rtl/btn_repeat.sv
// Press-to-pulse with hold-to-auto-repeat for one debounced edit button.
module btn_repeat #(
    parameter int HOLD_DELAY_CYC = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    localparam int MAX_CYC = (HOLD_DELAY_CYC > REPEAT_CYC) ? HOLD_DELAY_CYC : REPEAT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic             r_level_q;
    logic             r_rep;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;
    logic             w_press;
    logic             w_fire;

    // r_cnt equals cycles since the press (or since the last repeat pulse).
    assign w_press = level & ~r_level_q;
    assign w_limit = r_rep ? CNT_W'(REPEAT_CYC) : CNT_W'(HOLD_DELAY_CYC);
    assign w_fire  = level & r_level_q & (r_cnt == w_limit);
    assign pulse   = reset & (w_press | w_fire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_q <= 1'b0;
            r_rep     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_level_q <= level;
            if (!level) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (w_press) begin
                r_cnt <= CNT_W'(1);
                r_rep <= 1'b0;
            end else if (w_fire) begin
                r_cnt <= CNT_W'(1);
                r_rep <= 1'b1;
            end else if (r_cnt < w_limit) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock control: routes edit presses to clock or alarm, and sequences
// arm, ring, snooze and ring timeout.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int HOLD_DELAY_CYC = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       mode,
    input  logic [1:0] edit_btns,
    input  logic       btn_snooze,
    input  logic       btn_arm,
    input  logic       alarm_match,
    output logic [1:0] time_inc,
    output logic [1:0] alarm_inc,
    output logic       armed,
    output logic       ringing,
    output logic       buzzer
);
    localparam int RING_W = $clog2(RING_TIMEOUT_S + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_S + 1);
    localparam int NUM_W  = $clog2(MAX_SNOOZE + 1);

    alarm_state_t      r_state, w_state_nx;
    logic [RING_W-1:0] r_ring_cnt, w_ring_cnt_nx, w_ring_inc;
    logic [SNZ_W-1:0]  r_snz_cnt, w_snz_cnt_nx, w_snz_dec;
    logic [NUM_W-1:0]  r_snz_num, w_snz_num_nx;
    logic              r_beep, w_beep_nx;
    logic              r_arm_q, r_snz_q, r_match_q;
    logic              w_arm_press, w_snz_press, w_trigger;
    logic [1:0]        w_pulse;

    for (genvar g = 0; g < 2; g++) begin : g_edit
        btn_repeat #(
            .HOLD_DELAY_CYC(HOLD_DELAY_CYC),
            .REPEAT_CYC    (REPEAT_CYC)
        ) u_rep (
            .clk  (clk),
            .reset(reset),
            .level(edit_btns[g]),
            .pulse(w_pulse[g])
        );
    end

    // Routing follows mode in the pulse cycle, so a mid-hold flip retargets.
    assign time_inc  = mode ? 2'b00 : w_pulse;
    assign alarm_inc = mode ? w_pulse : 2'b00;

    assign w_arm_press = btn_arm & ~r_arm_q;
    assign w_snz_press = btn_snooze & ~r_snz_q;
    assign w_trigger   = tick_1hz & alarm_match & ~r_match_q;

    assign w_ring_inc = (r_ring_cnt == RING_W'(RING_TIMEOUT_S)) ? r_ring_cnt : r_ring_cnt + 1'b1;
    assign w_snz_dec  = (r_snz_cnt == '0) ? '0 : r_snz_cnt - 1'b1;

    always_comb begin
        w_state_nx    = r_state;
        w_ring_cnt_nx = r_ring_cnt;
        w_snz_cnt_nx  = r_snz_cnt;
        w_snz_num_nx  = r_snz_num;
        w_beep_nx     = r_beep;
        case (r_state)
            DISARMED: if (w_arm_press) w_state_nx = ARMED;
            ARMED: begin
                if (w_arm_press) begin
                    w_state_nx = DISARMED;
                end else if (w_trigger) begin
                    w_state_nx    = RINGING;
                    w_ring_cnt_nx = '0;
                    w_beep_nx     = 1'b1;
                    w_snz_num_nx  = '0;
                end
            end
            RINGING: begin
                if (w_arm_press) begin
                    w_state_nx = ARMED;
                end else if (w_snz_press && (r_snz_num < NUM_W'(MAX_SNOOZE))) begin
                    w_state_nx   = SNOOZING;
                    w_snz_cnt_nx = SNZ_W'(SNOOZE_S);
                    w_snz_num_nx = r_snz_num + 1'b1;
                end else if (tick_1hz) begin
                    w_ring_cnt_nx = w_ring_inc;
                    w_beep_nx     = ~r_beep;
                    if (w_ring_inc == RING_W'(RING_TIMEOUT_S)) w_state_nx = ARMED;
                end
            end
            SNOOZING: begin
                if (w_arm_press) begin
                    w_state_nx = ARMED;
                end else if (tick_1hz) begin
                    w_snz_cnt_nx = w_snz_dec;
                    if (w_snz_dec == '0) begin
                        w_state_nx    = RINGING;
                        w_ring_cnt_nx = '0;
                        w_beep_nx     = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= DISARMED;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_snz_num  <= '0;
            r_beep     <= 1'b0;
            r_arm_q    <= 1'b0;
            r_snz_q    <= 1'b0;
            r_match_q  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ring_cnt <= w_ring_cnt_nx;
            r_snz_cnt  <= w_snz_cnt_nx;
            r_snz_num  <= w_snz_num_nx;
            r_beep     <= w_beep_nx;
            r_arm_q    <= btn_arm;
            r_snz_q    <= btn_snooze;
            if (tick_1hz) r_match_q <= alarm_match;
        end
    end

    assign armed   = (r_state != DISARMED);
    assign ringing = (r_state == RINGING);
    assign buzzer  = ringing & r_beep;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a cycle-level reference model of the behaviour.
module tb_alarm_sequencer;
    localparam int H  = 8;
    localparam int R  = 4;
    localparam int SN = 3;
    localparam int RT = 5;
    localparam int MS = 2;
    localparam int S_DIS = 0, S_ARM = 1, S_RING = 2, S_SNZ = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0, mode = 1'b0, btn_snooze = 1'b0, btn_arm = 1'b0, alarm_match = 1'b0;
    logic [1:0] edit_btns = 2'b00;
    logic [1:0] time_inc, alarm_inc;
    logic       armed, ringing, buzzer;

    int n_checks = 0;
    int n_pass   = 0;

    alarm_sequencer #(
        .HOLD_DELAY_CYC(H), .REPEAT_CYC(R), .SNOOZE_S(SN),
        .RING_TIMEOUT_S(RT), .MAX_SNOOZE(MS)
    ) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .mode(mode),
        .edit_btns(edit_btns), .btn_snooze(btn_snooze), .btn_arm(btn_arm),
        .alarm_match(alarm_match), .time_inc(time_inc), .alarm_inc(alarm_inc),
        .armed(armed), .ringing(ringing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: hold age per edit bit, and the alarm as a few counters.
    int   m_age [2];
    logic m_prev_edit [2];
    logic m_prev_arm, m_prev_snz, m_mq;
    int   m_st, m_ring_ticks, m_snz_left, m_snz_used;

    always @(negedge clk) begin
        if (!reset) begin
            m_age[0] = -1; m_age[1] = -1;
            m_prev_edit[0] = 1'b0; m_prev_edit[1] = 1'b0;
            m_prev_arm = 1'b0; m_prev_snz = 1'b0; m_mq = 1'b0;
            m_st = S_DIS; m_ring_ticks = 0; m_snz_left = 0; m_snz_used = 0;
            chk("reset_outs", {time_inc, alarm_inc, armed, ringing, buzzer}, 0);
        end else begin
            logic [1:0] p;
            logic arm_p, snz_p, trig;
            int age;
            for (int b = 0; b < 2; b++) begin
                age = !edit_btns[b] ? -1 : (!m_prev_edit[b] ? 0 : m_age[b] + 1);
                p[b] = edit_btns[b] && (age == 0 || age == H || (age > H && (age - H) % R == 0));
                m_age[b] = age;
                m_prev_edit[b] = edit_btns[b];
            end
            chk("edit_inc", {time_inc, alarm_inc}, mode ? {2'b00, p} : {p, 2'b00});
            chk("status", {armed, ringing, buzzer},
                {m_st != S_DIS, m_st == S_RING, m_st == S_RING && (m_ring_ticks % 2 == 0)});

            arm_p = btn_arm && !m_prev_arm;
            snz_p = btn_snooze && !m_prev_snz;
            trig  = tick_1hz && alarm_match && !m_mq;
            m_prev_arm = btn_arm;
            m_prev_snz = btn_snooze;
            if (tick_1hz) m_mq = alarm_match;
            case (m_st)
                S_DIS: if (arm_p) m_st = S_ARM;
                S_ARM: begin
                    if (arm_p) m_st = S_DIS;
                    else if (trig) begin m_st = S_RING; m_ring_ticks = 0; m_snz_used = 0; end
                end
                S_RING: begin
                    if (arm_p) m_st = S_ARM;
                    else if (snz_p && m_snz_used < MS) begin
                        m_st = S_SNZ; m_snz_left = SN; m_snz_used++;
                    end else if (tick_1hz) begin
                        m_ring_ticks++;
                        if (m_ring_ticks >= RT) m_st = S_ARM;
                    end
                end
                default: begin
                    if (arm_p) m_st = S_ARM;
                    else if (tick_1hz) begin
                        m_snz_left--;
                        if (m_snz_left <= 0) begin m_st = S_RING; m_ring_ticks = 0; end
                    end
                end
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
    endtask

    task automatic press_arm();
        btn_arm = 1'b1; step(1); btn_arm = 1'b0; step(1);
    endtask

    task automatic press_snz();
        btn_snooze = 1'b1; step(1); btn_snooze = 1'b0; step(1);
    endtask

    // Hold edit_btns[1] for 20 cycles, optionally flipping mode to 0 at cycle 10.
    task automatic hold_run(input logic start_mode, input bit flip,
                            output int tq[$], output int aq[$]);
        tq = {}; aq = {};
        mode = start_mode; edit_btns = 2'b10;
        for (int i = 0; i < 20; i++) begin
            if (flip && i == 10) mode = 1'b0;
            #2;
            if (time_inc[1]) tq.push_back(i);
            if (alarm_inc[1]) aq.push_back(i);
            step(1);
        end
        edit_btns = 2'b00; mode = 1'b0;
        step(2);
    endtask

    initial begin
        int tq[$], aq[$];
        step(2);
        #2;
        chk("reset_status", {armed, ringing, buzzer, time_inc, alarm_inc}, 0);
        step(1);
        reset = 1'b1;
        step(2);

        hold_run(1'b0, 1'b0, tq, aq);
        chk("hold_time_cnt", tq.size(), 4);
        chk("hold_alarm_cnt", aq.size(), 0);
        if (tq.size() == 4) chk("hold_time_cyc", {tq[0][7:0], tq[1][7:0], tq[2][7:0], tq[3][7:0]}, 32'h00080C10);

        hold_run(1'b1, 1'b1, tq, aq);
        chk("retarget_cnt", {tq.size(), aq.size()}, {32'd2, 32'd2});
        if (tq.size() == 2 && aq.size() == 2)
            chk("retarget_cyc", {aq[0][7:0], aq[1][7:0], tq[0][7:0], tq[1][7:0]}, 32'h0008_0C10);

        edit_btns = 2'b11; step(14); edit_btns = 2'b00; step(2);

        press_arm();
        #2; chk("armed_after_press", {armed, ringing}, 2'b10);
        alarm_match = 1'b1; step(1);
        do_tick();
        #2; chk("ring_start", {ringing, buzzer}, 2'b11);
        for (int k = 1; k <= 5; k++) begin
            step(2);
            do_tick();
            #2;
            if (k < 5) chk("beep_phase", buzzer, (k % 2 == 0));
            else chk("timeout_armed", {armed, ringing, buzzer}, 3'b100);
        end

        alarm_match = 1'b0; do_tick();
        alarm_match = 1'b1; do_tick();
        #2; chk("retrigger", ringing, 1'b1);
        for (int s = 0; s < 2; s++) begin
            press_snz();
            #2; chk("snoozing", {armed, ringing}, 2'b10);
            for (int k = 1; k <= 3; k++) begin
                step(1); do_tick(); #2;
                chk("snooze_tick", ringing, (k == 3));
            end
        end
        press_snz();
        #2; chk("snooze_max_ignored", ringing, 1'b1);
        press_arm();
        #2; chk("arm_stops", {armed, ringing}, 2'b10);

        alarm_match = 1'b0; do_tick();
        alarm_match = 1'b1; btn_arm = 1'b1; tick_1hz = 1'b1;
        step(1);
        btn_arm = 1'b0; tick_1hz = 1'b0;
        #2; chk("arm_beats_trigger", {armed, ringing}, 2'b00);
        step(2); do_tick(); #2;
        chk("no_ring_disarmed", ringing, 1'b0);

        press_arm();
        alarm_match = 1'b0; do_tick();
        alarm_match = 1'b1; do_tick();
        #2; chk("ring_before_reset", ringing, 1'b1);
        reset = 1'b0;
        #1; chk("async_reset_outs", {armed, ringing, buzzer}, 3'b000);
        step(2);
        reset = 1'b1;
        step(1);
        do_tick(); step(1);
        alarm_match = 1'b0; do_tick();
        alarm_match = 1'b1; do_tick();
        #2; chk("post_reset_no_ring", {armed, ringing}, 2'b00);
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
